alu_load_sequencer: RTL and testbench



---
 rtl/alu_load_sequencer_pkg.sv | 35 +++
 rtl/alu_load_sequencer_btn_debounce.sv | 51 +++++
 rtl/alu_load_sequencer.sv | 130 +++++++++++++
 tb/tb_alu_load_sequencer.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_load_sequencer_pkg.sv
// Package shared by the ALU load sequencer and its button front end.
// Contents:
//   state_t  - FSM state encoding, which is also driven onto STATE_OUT
//   C_*      - bit positions of the fields inside the 10-bit control word
//   FLAG_*   - bit positions inside the 4-bit {z,v,c,n} flag vector
//   exactly_one() - true when exactly one bit of a 3-bit vector is set
package alu_load_sequencer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_SETTLE = 2'b01,
        ST_COMMIT = 2'b10
    } state_t;

    localparam int C_WIDTH       = 10;
    localparam int C_HEX_MODE_HI = 9;
    localparam int C_HEX_MODE_LO = 8;
    localparam int C_HEX_SHOW_HI = 7;
    localparam int C_HEX_SHOW_LO = 6;
    localparam int C_LED_SHOW_HI = 5;
    localparam int C_LED_SHOW_LO = 4;
    localparam int C_CARRY       = 3;
    localparam int C_OP_HI       = 2;
    localparam int C_OP_LO       = 0;

    localparam int FLAG_N = 0;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 2;
    localparam int FLAG_Z = 3;

    function automatic logic exactly_one(input logic [2:0] v);
        return (v == 3'b001) || (v == 3'b010) || (v == 3'b100);
    endfunction

endpackage

// File: rtl/alu_load_sequencer_btn_debounce.sv
// One button input path: two-flop synchroniser, debounce counter and a
// single-cycle press pulse on the debounced 0->1 transition.
// Ports:
//   clk    - system clock
//   rst_n  - synchronous active-low reset
//   btn    - raw asynchronous button, high = pressed
//   press  - one-cycle pulse when the debounced level rises
module btn_debounce #(
    parameter int DEB_CYCLES = 50000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn,
    output logic press
);

    localparam int CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES + 1) : 1;

    logic          sync_1;
    logic          sync_2;
    logic          level;
    logic [CW-1:0] cnt;
    logic          flip;

    // The level flips on the edge that completes DEB_CYCLES consecutive
    // cycles of disagreement between the synced input and the debounced level.
    assign flip = (sync_2 != level) && (cnt == CW'(DEB_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_1 <= 1'b0;
            sync_2 <= 1'b0;
            level  <= 1'b0;
            cnt    <= '0;
            press  <= 1'b0;
        end else begin
            sync_1 <= btn;
            sync_2 <= sync_1;
            press  <= flip && !level;
            if (sync_2 == level) begin
                cnt <= '0;
            end else if (flip) begin
                cnt   <= '0;
                level <= ~level;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/alu_load_sequencer.sv
// Clocked front end for the switch/button ALU datapath. Debounced presses
// of B0/B1/B2 load A, B or the control word C from SWITCH; the sequencer
// then waits SETTLE_CYC cycles for the combinational ALU and commits its
// result and flags into holding registers.
// Ports:
//   CLK, RST_N          - clock, synchronous active-low reset
//   SWITCH              - data source for every load
//   B0, B1, B2          - raw buttons loading A, B, C
//   ALU_RES, ALU_FLAGS  - combinational ALU outputs ({z,v,c,n})
//   A_OUT, B_OUT, C_OUT - operand and control registers feeding the ALU
//   RES_OUT, FLAGS_OUT  - committed result and flags
//   BUSY                - high in SETTLE and COMMIT
//   VALID               - committed outputs match the current A/B/C
//   STATE_OUT           - FSM state for debug LEDs
//
// state     | meaning
// ST_IDLE   | waiting for exactly one press pulse; loads are accepted here only
// ST_SETTLE | register just loaded, giving the ALU SETTLE_CYC cycles to settle
// ST_COMMIT | one cycle; its closing edge captures ALU_RES/ALU_FLAGS
module alu_load_sequencer
    import alu_load_sequencer_pkg::*;
#(
    parameter int N          = 10,
    parameter int DEB_CYCLES = 50000,
    parameter int SETTLE_CYC = 2
) (
    input  logic               CLK,
    input  logic               RST_N,
    input  logic [9:0]         SWITCH,
    input  logic               B0,
    input  logic               B1,
    input  logic               B2,
    input  logic [N-1:0]       ALU_RES,
    input  logic [3:0]         ALU_FLAGS,
    output logic [N-1:0]       A_OUT,
    output logic [N-1:0]       B_OUT,
    output logic [C_WIDTH-1:0] C_OUT,
    output logic [N-1:0]       RES_OUT,
    output logic [3:0]         FLAGS_OUT,
    output logic               BUSY,
    output logic               VALID,
    output logic [1:0]         STATE_OUT
);

    localparam int SCW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC + 1) : 1;

    state_t         state;
    state_t         state_nxt;
    logic [SCW-1:0] settle_cnt;
    logic [SCW-1:0] settle_cnt_nxt;
    logic [2:0]     press;
    logic           load_a;
    logic           load_b;
    logic           load_c;
    logic           do_commit;

    btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_b0 (
        .clk(CLK), .rst_n(RST_N), .btn(B0), .press(press[0])
    );
    btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_b1 (
        .clk(CLK), .rst_n(RST_N), .btn(B1), .press(press[1])
    );
    btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_b2 (
        .clk(CLK), .rst_n(RST_N), .btn(B2), .press(press[2])
    );

    always_comb begin
        state_nxt      = state;
        settle_cnt_nxt = settle_cnt;
        load_a         = 1'b0;
        load_b         = 1'b0;
        load_c         = 1'b0;
        do_commit      = 1'b0;
        case (state)
            ST_IDLE: begin
                // Coincident pulses are ambiguous, so they are all ignored.
                if (exactly_one(press)) begin
                    load_a         = press[0];
                    load_b         = press[1];
                    load_c         = press[2];
                    settle_cnt_nxt = '0;
                    state_nxt      = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                if (settle_cnt == SCW'(SETTLE_CYC - 1)) begin
                    state_nxt = ST_COMMIT;
                end else begin
                    settle_cnt_nxt = settle_cnt + SCW'(1);
                end
            end
            ST_COMMIT: begin
                do_commit = 1'b1;
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state      <= ST_IDLE;
            settle_cnt <= '0;
            A_OUT      <= '0;
            B_OUT      <= '0;
            C_OUT      <= '0;
            RES_OUT    <= '0;
            FLAGS_OUT  <= '0;
            VALID      <= 1'b0;
        end else begin
            state      <= state_nxt;
            settle_cnt <= settle_cnt_nxt;
            if (load_a) A_OUT <= SWITCH[N-1:0];
            if (load_b) B_OUT <= SWITCH[N-1:0];
            if (load_c) C_OUT <= SWITCH[C_WIDTH-1:0];
            if (load_a || load_b || load_c) VALID <= 1'b0;
            if (do_commit) begin
                RES_OUT   <= ALU_RES;
                FLAGS_OUT <= ALU_FLAGS;
                VALID     <= 1'b1;
            end
        end
    end

    assign BUSY      = (state == ST_SETTLE) || (state == ST_COMMIT);
    assign STATE_OUT = state;

endmodule

// File: tb/tb_alu_load_sequencer.sv
module tb_alu_load_sequencer;

    localparam int N    = 10;
    localparam int DEB  = 4;
    localparam int SETL = 2;

    logic         CLK = 1'b0;
    logic         RST_N;
    logic [9:0]   SWITCH;
    logic [2:0]   btn;
    logic [N-1:0] ALU_RES;
    logic [3:0]   ALU_FLAGS;
    logic [N-1:0] A_OUT, B_OUT, RES_OUT;
    logic [9:0]   C_OUT;
    logic [3:0]   FLAGS_OUT;
    logic         BUSY, VALID;
    logic [1:0]   STATE_OUT;

    always #5 CLK = ~CLK;

    alu_load_sequencer #(.N(N), .DEB_CYCLES(DEB), .SETTLE_CYC(SETL)) dut (
        .CLK(CLK), .RST_N(RST_N), .SWITCH(SWITCH),
        .B0(btn[0]), .B1(btn[1]), .B2(btn[2]),
        .ALU_RES(ALU_RES), .ALU_FLAGS(ALU_FLAGS),
        .A_OUT(A_OUT), .B_OUT(B_OUT), .C_OUT(C_OUT),
        .RES_OUT(RES_OUT), .FLAGS_OUT(FLAGS_OUT),
        .BUSY(BUSY), .VALID(VALID), .STATE_OUT(STATE_OUT)
    );

    // Behavioural ALU environment: op 000 add with carry-in, 001 sub,
    // 010 and, 011 or, 100 xor, others pass A. Flags are {z,v,c,n}.
    always_comb begin
        logic [10:0] w;
        logic [9:0]  r;
        logic        c, v;
        w = '0; c = 1'b0; v = 1'b0;
        case (C_OUT[2:0])
            3'b000: begin
                w = {1'b0, A_OUT} + {1'b0, B_OUT} + {10'b0, C_OUT[3]};
                c = w[10];
                v = (A_OUT[9] == B_OUT[9]) && (w[9] != A_OUT[9]);
            end
            3'b001: begin
                w = {1'b0, A_OUT} - {1'b0, B_OUT};
                c = w[10];
                v = (A_OUT[9] != B_OUT[9]) && (w[9] != A_OUT[9]);
            end
            3'b010:  w = {1'b0, A_OUT & B_OUT};
            3'b011:  w = {1'b0, A_OUT | B_OUT};
            3'b100:  w = {1'b0, A_OUT ^ B_OUT};
            default: w = {1'b0, A_OUT};
        endcase
        r         = w[9:0];
        ALU_RES   = r;
        ALU_FLAGS = {(r == 10'd0), v, c, r[9]};
    end

    typedef struct {
        logic [9:0] res;
        logic [3:0] flags;
    } exp_t;

    typedef struct {
        int         b;
        logic [9:0] sw;
        logic [9:0] res;
        logic [3:0] flags;
    } vec_t;

    exp_t sb[$];
    exp_t e;
    vec_t vecs[10];

    int n_vec = 0;
    int n_err = 0;
    int busy_rises = 0;
    int valid_rises = 0;
    logic prev_busy = 1'b0;
    logic prev_valid = 1'b0;
    logic [9:0] m_a, m_b, m_c;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard: every commit (VALID rising) pops the oldest expectation.
    always @(negedge CLK) begin
        if (BUSY && !prev_busy) busy_rises++;
        if (VALID && !prev_valid) begin
            valid_rises++;
            if (sb.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_commit: got RES 0x%0h, expected no commit", RES_OUT);
            end else begin
                e = sb.pop_front();
                check("commit_res", RES_OUT, e.res);
                check("commit_flags", FLAGS_OUT, e.flags);
            end
        end
        prev_busy  = BUSY;
        prev_valid = VALID;
    end

    task automatic wait_busy(output bit ok);
        ok = 1'b0;
        for (int k = 0; k < 30; k++) begin
            @(negedge CLK);
            if (BUSY) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic do_vec(input vec_t v);
        bit ok;
        int cnt;
        SWITCH   = v.sw;
        btn[v.b] = 1'b1;
        sb.push_back('{res: v.res, flags: v.flags});
        case (v.b)
            0:       m_a = v.sw;
            1:       m_b = v.sw;
            default: m_c = v.sw;
        endcase
        wait_busy(ok);
        check("load_seen", {31'd0, ok}, 32'd1);
        check("load_a", A_OUT, m_a);
        check("load_b", B_OUT, m_b);
        check("load_c", C_OUT, m_c);
        check("valid_cleared", VALID, 1'b0);
        check("state_settle", STATE_OUT, 2'b01);
        SWITCH = ~v.sw;
        cnt = 0;
        for (int k = 0; k < 10 && !VALID; k++) begin
            @(negedge CLK);
            cnt++;
        end
        check("commit_latency", cnt, SETL + 1);
        check("busy_after_commit", BUSY, 1'b0);
        btn[v.b] = 1'b0;
        repeat (12) @(negedge CLK);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_a"}, A_OUT, 0);
        check({tag, "_b"}, B_OUT, 0);
        check({tag, "_c"}, C_OUT, 0);
        check({tag, "_res"}, RES_OUT, 0);
        check({tag, "_flags"}, FLAGS_OUT, 0);
        check({tag, "_busy"}, BUSY, 0);
        check({tag, "_valid"}, VALID, 0);
        check({tag, "_state"}, STATE_OUT, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected $finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit ok;
        int br0, vr0;

        vecs[0] = '{b: 0, sw: 10'h005, res: 10'h005, flags: 4'b0000};
        vecs[1] = '{b: 1, sw: 10'h003, res: 10'h008, flags: 4'b0000};
        vecs[2] = '{b: 2, sw: 10'h000, res: 10'h008, flags: 4'b0000};
        vecs[3] = '{b: 0, sw: 10'h3FF, res: 10'h002, flags: 4'b0010};
        vecs[4] = '{b: 2, sw: 10'h008, res: 10'h003, flags: 4'b0010};
        vecs[5] = '{b: 1, sw: 10'h001, res: 10'h001, flags: 4'b0010};
        vecs[6] = '{b: 2, sw: 10'h004, res: 10'h3FE, flags: 4'b0001};
        vecs[7] = '{b: 0, sw: 10'h001, res: 10'h000, flags: 4'b1000};
        vecs[8] = '{b: 0, sw: 10'h1FF, res: 10'h1FE, flags: 4'b0000};
        vecs[9] = '{b: 2, sw: 10'h000, res: 10'h200, flags: 4'b0101};

        // Reset with activity on the inputs.
        RST_N = 1'b0; SWITCH = 10'h3FF; btn = 3'b000;
        m_a = '0; m_b = '0; m_c = '0;
        for (int k = 0; k < 3; k++) begin
            btn[0] = ~btn[0];
            @(negedge CLK);
        end
        check_all_zero("rst");
        btn = 3'b000; RST_N = 1'b1;
        repeat (10) @(negedge CLK);
        check_all_zero("idle");

        // Table-driven loads and commits.
        for (int i = 0; i < 10; i++) do_vec(vecs[i]);

        // Short glitch on B1 must not load.
        br0 = busy_rises;
        SWITCH = 10'h2AA; btn[1] = 1'b1;
        repeat (3) @(negedge CLK);
        btn[1] = 1'b0;
        repeat (12) @(negedge CLK);
        check("glitch_no_load", busy_rises - br0, 0);
        check("glitch_b", B_OUT, m_b);

        // Long hold on B1 loads exactly once.
        br0 = busy_rises;
        SWITCH = 10'h005; btn[1] = 1'b1; m_b = 10'h005;
        sb.push_back('{res: 10'h204, flags: 4'b0101});
        repeat (25) @(negedge CLK);
        btn[1] = 1'b0;
        repeat (12) @(negedge CLK);
        check("hold_one_load", busy_rises - br0, 1);
        check("hold_b", B_OUT, 10'h005);

        // Simultaneous B0/B1 presses are ignored.
        br0 = busy_rises;
        SWITCH = 10'h3AA; btn[0] = 1'b1; btn[1] = 1'b1;
        repeat (12) @(negedge CLK);
        check("simul_no_load", busy_rises - br0, 0);
        check("simul_a", A_OUT, m_a);
        check("simul_b", B_OUT, m_b);
        check("simul_state", STATE_OUT, 2'b00);
        btn = 3'b000;
        repeat (12) @(negedge CLK);

        // B0 pulse arrives while busy with a B1 load: dropped, not queued.
        br0 = busy_rises; vr0 = valid_rises;
        SWITCH = 10'h002; btn[1] = 1'b1; m_b = 10'h002;
        sb.push_back('{res: 10'h201, flags: 4'b0101});
        @(negedge CLK);
        btn[0] = 1'b1;
        wait_busy(ok);
        check("drop_load_seen", {31'd0, ok}, 32'd1);
        repeat (20) @(negedge CLK);
        check("drop_a", A_OUT, m_a);
        check("drop_b", B_OUT, 10'h002);
        check("drop_one_load", busy_rises - br0, 1);
        check("drop_one_valid", valid_rises - vr0, 1);
        btn = 3'b000;
        repeat (12) @(negedge CLK);

        // Reset during SETTLE aborts the load; no commit follows.
        vr0 = valid_rises;
        SWITCH = 10'h077; btn[0] = 1'b1;
        wait_busy(ok);
        check("rst_mid_load_seen", {31'd0, ok}, 32'd1);
        check("rst_mid_a", A_OUT, 10'h077);
        btn[0] = 1'b0; RST_N = 1'b0;
        @(negedge CLK);
        check_all_zero("rst_mid");
        RST_N = 1'b1;
        repeat (12) @(negedge CLK);
        check("rst_mid_no_commit", valid_rises - vr0, 0);
        check("rst_mid_valid", VALID, 1'b0);
        check("rst_mid_res", RES_OUT, 0);
        check("sb_drained", sb.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
